// File: rtl/fsm_rr_arbiter.sv
// ============================================================================
// Module   : fsm_rr_arbiter
// Purpose  : Four-requester round-robin arbiter that owns the single serial
//            input of a downstream FSM. A small controller (IDLE/GRANT/GAP)
//            hands the input to one requester at a time and inserts a
//            one-cycle turnaround gap between owners.
// Options  : define FSM_ARB_BURST_EN to cap each grant at BURST_LEN cycles;
//            without it the owner keeps the grant until it drops req.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_rr_arbiter #(
  parameter int BURST_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] in_bits,
  output logic [3:0] grant,
  output logic [1:0] gnt_id,
  output logic       in_sel,
  output logic [1:0] state,
  output logic       busy
);

  // Controller state encoding is visible on the state port, so it is fixed.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;

  // Burst counter is sized for the largest legal BURST_LEN (16).
  localparam int         CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  // Reject illegal burst lengths at elaboration time.
  if ((BURST_LEN < 2) || (BURST_LEN > 16)) begin : g_bad_burst_len
    $error("fsm_rr_arbiter: BURST_LEN must be in 2..16");
  end

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,     state_d;
  logic [3:0]       grant_q,     grant_d;
  logic [1:0]       gnt_id_q,    gnt_id_d;
  logic [1:0]       last_id_q,   last_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // --------------------------------------------------------------------------
  // Round-robin pick: the search starts one past the last owner and wraps.
  // Walking the offsets from lowest to highest priority and overwriting
  // leaves the highest-priority set bit as the result.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = last + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  logic [1:0] winner;
  logic       any_req;
  logic       owner_req;
  logic       burst_done;

  assign winner    = rr_pick(req, last_id_q);
  assign any_req   = |req;
  assign owner_req = req[gnt_id_q];

`ifdef FSM_ARB_BURST_EN
  // The grant ends on the cycle where the counter reaches its ceiling, so the
  // owner sees exactly BURST_LEN GRANT cycles.
  assign burst_done = (burst_cnt_q == CNT_MAX);
`else
  // No burst limit: only the owner dropping its request ends a grant.
  assign burst_done = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic for the IDLE/GRANT/GAP controller
  // --------------------------------------------------------------------------
  // Computes the next controller state, grant vector and bookkeeping.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gnt_id_d    = gnt_id_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        // Arbitration happens only here; GAP therefore always lasts one cycle.
        if (any_req) begin
          state_d     = ST_GRANT;
          grant_d     = 4'b0001 << winner;
          gnt_id_d    = winner;
          burst_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
        end
      end

      ST_GRANT: begin
        // Only the owner's own request (and the burst cap) is looked at, so
        // other requesters cannot disturb an active grant.
        if (!owner_req || burst_done) begin
          state_d   = ST_GAP;
          grant_d   = 4'b0000;
          last_id_d = gnt_id_q;
        end else if (burst_cnt_q != CNT_MAX) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end

      default: begin
        // Unused encoding recovers to IDLE with no owner.
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers with asynchronous reset
  // --------------------------------------------------------------------------
  // Reset leaves last_id at 3 so requester 0 has first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 4'b0000;
      gnt_id_q    <= 2'd0;
      last_id_q   <= 2'd3;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gnt_id_q    <= gnt_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign grant  = grant_q;
  assign gnt_id = gnt_id_q;
  assign state  = state_q;
  assign busy   = (state_q == ST_GRANT);

  // Serial mux is driven from registered state only; zero whenever no owner.
  assign in_sel = (state_q == ST_GRANT) ? in_bits[gnt_id_q] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_fsm_rr_arbiter.sv
// ============================================================================
// Module   : tb_fsm_rr_arbiter
// Purpose  : Scoreboard bench for fsm_rr_arbiter. Stimulus pushes expected
//            outputs from a behavioural model; a monitor pops and compares
//            on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_rr_arbiter;

`ifdef FSM_ARB_BURST_EN
  localparam int BL       = 4;
  localparam bit BURST_ON = 1'b1;
`else
  localparam int BL       = 8;
  localparam bit BURST_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] in_bits;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       in_sel;
  logic [1:0] state;
  logic       busy;

  fsm_rr_arbiter #(.BURST_LEN(BL)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .in_bits (in_bits),
    .grant   (grant),
    .gnt_id  (gnt_id),
    .in_sel  (in_sel),
    .state   (state),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic [1:0] st;
    logic       b;
    logic       s;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, want);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: who owns the input, whether we sit in the turnaround
  // cycle, how long the owner has held it, and who owned it last.
  // ------------------------------------------------------------------------
  int m_owner;   // -1 when nobody owns the input
  bit m_gap;
  int m_id;
  int m_last;
  int m_cnt;

  function automatic void model_reset();
    m_owner = -1;
    m_gap   = 1'b0;
    m_id    = 0;
    m_last  = 3;
    m_cnt   = 0;
  endfunction

  // One rising edge, using the inputs the DUT sees at that edge.
  function automatic void model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      if (!req[m_owner] || (BURST_ON && m_cnt == BL - 1)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1'b1;
      end else if (m_cnt < BL - 1) begin
        m_cnt++;
      end
    end else begin
      m_gap = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_last + k) % 4;
        if (req[i]) begin
          m_owner = i;
          m_id    = i;
          m_cnt   = 0;
          break;
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.id = m_id[1:0];
    e.st = (m_owner >= 0) ? 2'b01 : (m_gap ? 2'b10 : 2'b00);
    e.b  = (m_owner >= 0);
    e.s  = (m_owner >= 0) ? in_bits[m_owner] : 1'b0;
    return e;
  endfunction

  // One clock of stimulus: advance the model at the edge, drive new inputs
  // just after it, and queue the outputs expected for the rest of the cycle.
  task automatic step(input logic rst_v, input logic [3:0] r,
                      input logic [3:0] d);
    @(posedge clk);
    model_edge();
    #1;
    rst     = rst_v;
    req     = r;
    in_bits = d;
    if (rst_v) model_reset();
    exp_q.push_back(model_out());
    if (rst_v) begin
      #1;
      chk("rst_async_grant", 32'(grant), 32'h0);
      chk("rst_async_state", 32'(state), 32'h0);
      chk("rst_async_insel", 32'(in_sel), 32'h0);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("grant",  32'(grant),  32'(e.g));
      chk("gnt_id", 32'(gnt_id), 32'(e.id));
      chk("state",  32'(state),  32'(e.st));
      chk("busy",   32'(busy),   32'(e.b));
      chk("in_sel", 32'(in_sel), 32'(e.s));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    logic       rv;
    rst     = 1'b1;
    req     = 4'b1111;
    in_bits = 4'b0000;
    model_reset();

    // Reset held with every requester asking, then release.
    repeat (3) step(1'b1, 4'b1111, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000);
    repeat (6) step(1'b0, 4'b1111, 4'($urandom));

    // Long hold by requester 0 while the others also request, then drop.
    repeat (20) step(1'b0, 4'b1111, 4'($urandom));
    repeat (4) step(1'b0, 4'b1110, 4'($urandom));

    // Drain to IDLE.
    repeat (4) step(1'b0, 4'b0000, 4'b0000);

    // Lone requester 2: data path and non-owner bit toggling, then drop.
    step(1'b0, 4'b0100, 4'b0100);
    step(1'b0, 4'b0100, 4'b0100);
    step(1'b0, 4'b0100, 4'b0000);
    step(1'b0, 4'b0100, 4'b1011);
    step(1'b0, 4'b0100, 4'b0000);
    step(1'b0, 4'b0100, 4'b1111);
    repeat (4) step(1'b0, 4'b0000, 4'b1111);

    // Owner drops while another asks in the same cycle.
    repeat (3) step(1'b0, 4'b0010, 4'b0010);
    step(1'b0, 4'b1000, 4'b1000);
    repeat (3) step(1'b0, 4'b1000, 4'b1000);
    repeat (3) step(1'b0, 4'b0000, 4'b0000);

    // Mid-grant reset while requester 2 owns the input.
    repeat (3) step(1'b0, 4'b0100, 4'b0100);
    repeat (2) step(1'b1, 4'b0101, 4'b0000);
    repeat (4) step(1'b0, 4'b0101, 4'b0001);

    // Everyone requesting continuously for a full rotation (burst cap).
    repeat (25) step(1'b0, 4'b1111, 4'($urandom));

    // Randomized traffic with sticky requests and rare resets.
    r = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      rv = ($urandom_range(0, 99) == 0);
      step(rv, r, 4'($urandom));
    end
    step(1'b0, 4'b0000, 4'b0000);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
